lsu_riscv: RTL and testbench

Load-store unit for the single-cycle RISC-V core. It is the responder for the decoder's memory-request controls (`mem_req`, `mem_we`, `mem_size`) and the initiator toward data memory. It converts one core access into a granted, acknowledged memory transaction with byte enables, lane replication and load sign/zero extension. It stalls the core for the duration of the transaction.

---
 rtl/lsu_riscv.sv | 145 ++++++++++++++
 tb/tb_lsu_riscv.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_riscv.sv
// Load-store unit: turns one core memory access into a granted, acknowledged
// data-memory transaction and stalls the core until the response arrives.
//
// state | meaning
// IDLE  | waiting for an aligned core request; captures the access
// REQ   | data_req_o asserted, waiting for data_gnt_i
// RESP  | waiting for data_rvalid_i; a load result is returned that cycle
module lsu_riscv (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_misaligned_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state, state_next;
    logic        is_half, is_word, is_unsigned, misaligned, capture;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic        half_q, word_q, unsigned_q;
    logic [1:0]  off_q;
    logic [31:0] load_q, load_ext;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        load_done;

    // Decode size; unlisted encodings and unsigned stores fall back to byte.
    always_comb begin
        is_half     = 1'b0;
        is_word     = 1'b0;
        is_unsigned = 1'b0;
        case (lsu_size_i)
            3'b001: is_half = 1'b1;
            3'b010: is_word = 1'b1;
            3'b100: is_unsigned = !lsu_we_i;
            3'b101: begin
                is_half     = !lsu_we_i;
                is_unsigned = !lsu_we_i;
            end
            default: ;
        endcase
        misaligned = (is_half & lsu_addr_i[0]) | (is_word & (lsu_addr_i[1:0] != 2'b00));
        if (is_word) begin
            be_next    = 4'b1111;
            wdata_next = lsu_data_i;
        end else if (is_half) begin
            be_next    = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{lsu_data_i[15:0]}};
        end else begin
            be_next    = 4'b0001 << lsu_addr_i[1:0];
            wdata_next = {4{lsu_data_i[7:0]}};
        end
    end

    assign capture = (state == IDLE) && lsu_req_i && !misaligned;

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_next;
    end

    // Next state and handshake/stall outputs.
    always_comb begin
        state_next       = state;
        data_req_o       = 1'b0;
        lsu_stall_req_o  = 1'b0;
        lsu_misaligned_o = 1'b0;
        case (state)
            IDLE: begin
                lsu_misaligned_o = lsu_req_i & misaligned;
                lsu_stall_req_o  = capture;
                if (capture) state_next = REQ;
            end
            REQ: begin
                data_req_o      = 1'b1;
                lsu_stall_req_o = 1'b1;
                if (data_gnt_i) state_next = RESP;
            end
            RESP: begin
                lsu_stall_req_o = !data_rvalid_i;
                if (data_rvalid_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Load lane extraction and extension from the captured offset/size.
    always_comb begin
        byte_sel = data_rdata_i[{off_q, 3'b000} +: 8];
        half_sel = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
        if (word_q)
            load_ext = data_rdata_i;
        else if (half_q)
            load_ext = {{16{half_sel[15] & !unsigned_q}}, half_sel};
        else
            load_ext = {{24{byte_sel[7] & !unsigned_q}}, byte_sel};
    end

    assign load_done  = (state == RESP) && data_rvalid_i && !data_we_o;
    assign lsu_data_o = load_done ? load_ext : load_q;

    // Access capture in IDLE and load result retention.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            data_we_o    <= 1'b0;
            data_be_o    <= 4'b0000;
            data_addr_o  <= 32'h0;
            data_wdata_o <= 32'h0;
            half_q       <= 1'b0;
            word_q       <= 1'b0;
            unsigned_q   <= 1'b0;
            off_q        <= 2'b00;
            load_q       <= 32'h0;
        end else begin
            if (capture) begin
                data_we_o    <= lsu_we_i;
                data_be_o    <= be_next;
                data_addr_o  <= {lsu_addr_i[31:2], 2'b00};
                data_wdata_o <= wdata_next;
                half_q       <= is_half;
                word_q       <= is_word;
                unsigned_q   <= is_unsigned;
                off_q        <= lsu_addr_i[1:0];
            end
            if (load_done) load_q <= load_ext;
        end
    end

endmodule

// File: tb/tb_lsu_riscv.sv
// Directed bench for lsu_riscv: vector table of single accesses plus
// hand-written grant-delay, reset-in-RESP and back-to-back sequences.
module tb_lsu_riscv;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        lsu_req_i, lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i, lsu_data_i;
    logic [31:0] lsu_data_o;
    logic        lsu_stall_req_o, lsu_misaligned_o;
    logic        data_req_o, data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic        data_gnt_i, data_rvalid_i;
    logic [31:0] data_rdata_i;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_load;

    lsu_riscv dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
        .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i), .lsu_data_o(lsu_data_o),
        .lsu_stall_req_o(lsu_stall_req_o), .lsu_misaligned_o(lsu_misaligned_o),
        .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] ewd;
        logic [31:0] edata;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One aligned access: capture, gdel cycles without grant, grant,
    // rdel RESP cycles without rvalid, then the rvalid cycle (inputs left set).
    task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int gdel, input int rdel,
                          input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] edata);
        @(negedge clk_i);
        lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size; lsu_addr_i = addr;
        lsu_data_i = wd; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        #1;
        chk("cap_stall", {31'b0, lsu_stall_req_o}, 32'd1);
        chk("cap_req", {31'b0, data_req_o}, 32'd0);
        chk("cap_mis", {31'b0, lsu_misaligned_o}, 32'd0);
        for (int i = 0; i <= gdel; i++) begin
            @(negedge clk_i);
            data_gnt_i = (i == gdel);
            #1;
            chk("req_valid", {31'b0, data_req_o}, 32'd1);
            chk("req_stall", {31'b0, lsu_stall_req_o}, 32'd1);
            chk("req_be", {28'b0, data_be_o}, {28'b0, ebe});
            chk("req_addr", data_addr_o, {addr[31:2], 2'b00});
            chk("req_wdata", data_wdata_o, ewd);
            chk("req_we", {31'b0, data_we_o}, {31'b0, we});
        end
        for (int i = 0; i < rdel; i++) begin
            @(negedge clk_i);
            data_gnt_i = 1'b0;
            #1;
            chk("resp_wait_stall", {31'b0, lsu_stall_req_o}, 32'd1);
            chk("resp_wait_req", {31'b0, data_req_o}, 32'd0);
        end
        @(negedge clk_i);
        data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = rd;
        #1;
        chk("rv_stall", {31'b0, lsu_stall_req_o}, 32'd0);
        chk("rv_req", {31'b0, data_req_o}, 32'd0);
        if (!we) begin
            chk("rv_data", lsu_data_o, edata);
            last_load = edata;
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk_i);
        lsu_req_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        #1;
        chk("idle_data_hold", lsu_data_o, last_load);
        chk("idle_stall", {31'b0, lsu_stall_req_o}, 32'd0);
    endtask

    initial begin
        //            we    size    addr          wd            rd            mis   be       ewd           edata
        vecs[0]  = '{1'b0, 3'b010, 32'h0000_0104, 32'h0,        32'hDEADBEEF, 1'b0, 4'b1111, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{1'b0, 3'b000, 32'h0000_0203, 32'h0,        32'h80112233, 1'b0, 4'b1000, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{1'b0, 3'b100, 32'h0000_0203, 32'h0,        32'h80112233, 1'b0, 4'b1000, 32'h0,        32'h00000080};
        vecs[3]  = '{1'b0, 3'b001, 32'h0000_0202, 32'h0,        32'h80112233, 1'b0, 4'b1100, 32'h0,        32'hFFFF8011};
        vecs[4]  = '{1'b0, 3'b101, 32'h0000_0200, 32'h0,        32'h80112233, 1'b0, 4'b0011, 32'h0,        32'h00002233};
        vecs[5]  = '{1'b0, 3'b000, 32'h0000_0201, 32'h0,        32'h80112233, 1'b0, 4'b0010, 32'h0,        32'h00000022};
        vecs[6]  = '{1'b1, 3'b010, 32'h0000_0400, 32'h11223344, 32'h0,        1'b0, 4'b1111, 32'h11223344, 32'h0};
        vecs[7]  = '{1'b1, 3'b000, 32'h0000_0001, 32'h000000A5, 32'h0,        1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0};
        vecs[8]  = '{1'b0, 3'b011, 32'h0000_0402, 32'h0,        32'h80112233, 1'b0, 4'b0100, 32'h0,        32'h00000011};
        vecs[9]  = '{1'b1, 3'b101, 32'h0000_0003, 32'h12345677, 32'h0,        1'b0, 4'b1000, 32'h77777777, 32'h0};
        vecs[10] = '{1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[11] = '{1'b1, 3'b001, 32'h0000_0303, 32'h1234ABCD, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[12] = '{1'b0, 3'b101, 32'h0000_0001, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};

        last_load = 32'h0;
        rst_n_i = 1'b0; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 3'b000;
        lsu_addr_i = 32'h0; lsu_data_i = 32'h0; data_gnt_i = 1'b0;
        data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
        chk("rst_req", {31'b0, data_req_o}, 32'd0);
        chk("rst_we", {31'b0, data_we_o}, 32'd0);
        chk("rst_be", {28'b0, data_be_o}, 32'd0);
        chk("rst_addr", data_addr_o, 32'd0);
        chk("rst_wdata", data_wdata_o, 32'd0);
        chk("rst_data", lsu_data_o, 32'd0);
        chk("rst_stall", {31'b0, lsu_stall_req_o}, 32'd0);
        chk("rst_mis", {31'b0, lsu_misaligned_o}, 32'd0);

        for (int v = 0; v < 13; v++) begin
            if (vecs[v].mis) begin
                @(negedge clk_i);
                lsu_req_i = 1'b1; lsu_we_i = vecs[v].we; lsu_size_i = vecs[v].size;
                lsu_addr_i = vecs[v].addr; lsu_data_i = vecs[v].wd;
                #1;
                chk("mis_flag", {31'b0, lsu_misaligned_o}, 32'd1);
                chk("mis_stall", {31'b0, lsu_stall_req_o}, 32'd0);
                chk("mis_req", {31'b0, data_req_o}, 32'd0);
                @(negedge clk_i);
                lsu_req_i = 1'b0;
                #1;
                chk("mis_flag_clear", {31'b0, lsu_misaligned_o}, 32'd0);
                chk("mis_req_after", {31'b0, data_req_o}, 32'd0);
            end else begin
                access(vecs[v].we, vecs[v].size, vecs[v].addr, vecs[v].wd, vecs[v].rd,
                       0, 0, vecs[v].be, vecs[v].ewd, vecs[v].edata);
                idle_cycle();
            end
        end

        // Half store with grant delayed 3 cycles and a slow response.
        access(1'b1, 3'b001, 32'h0000_0302, 32'h1234ABCD, 32'h0, 3, 2,
               4'b1100, 32'hABCDABCD, 32'h0);
        idle_cycle();

        // Back-to-back LW then SB, second captured the cycle after rvalid.
        access(1'b0, 3'b010, 32'h0000_0008, 32'h0, 32'hCAFEF00D, 0, 0,
               4'b1111, 32'h0, 32'hCAFEF00D);
        access(1'b1, 3'b000, 32'h0000_0001, 32'h0000005A, 32'h0, 0, 0,
               4'b0010, 32'h5A5A5A5A, 32'h0);
        idle_cycle();

        // Reset while in RESP; a stray rvalid afterwards must be ignored.
        @(negedge clk_i);
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'b010;
        lsu_addr_i = 32'h0000_0010; lsu_data_i = 32'h0;
        @(negedge clk_i);
        data_gnt_i = 1'b1;
        @(negedge clk_i);
        data_gnt_i = 1'b0;
        #1;
        chk("resp_stall_pre_rst", {31'b0, lsu_stall_req_o}, 32'd1);
        rst_n_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1; lsu_req_i = 1'b0;
        #1;
        chk("mrst_req", {31'b0, data_req_o}, 32'd0);
        chk("mrst_we", {31'b0, data_we_o}, 32'd0);
        chk("mrst_be", {28'b0, data_be_o}, 32'd0);
        chk("mrst_addr", data_addr_o, 32'd0);
        chk("mrst_wdata", data_wdata_o, 32'd0);
        chk("mrst_data", lsu_data_o, 32'd0);
        chk("mrst_stall", {31'b0, lsu_stall_req_o}, 32'd0);
        @(negedge clk_i);
        data_rvalid_i = 1'b1; data_rdata_i = 32'hFFFFFFFF;
        #1;
        chk("stray_rv_data", lsu_data_o, 32'd0);
        chk("stray_rv_stall", {31'b0, lsu_stall_req_o}, 32'd0);
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        #1;
        chk("stray_after_data", lsu_data_o, 32'd0);
        chk("stray_after_req", {31'b0, data_req_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
